// File: rtl/axi_arbiter_stom_rr.sv
// rtl/axi_arbiter_stom_rr.sv - slave-to-master R/B response arbiter, round-robin or fixed priority
//
// Two independent arbiters share this module: one for the write-response
// (B) channel and one for the read-data (R) channel.  Each one grants a
// single slave port and holds that grant until its response completes.
//
// Ports:
//   ACLK     clock
//   ARESET   synchronous reset, active-high; forces both grants to zero
//   BSELECT  per-slave: B response is addressed to this master
//   BVALID   per-slave BVALID
//   BREADY   per-slave BREADY routed back from the master
//   BGRANT   one-hot or zero B-channel winner
//   RSELECT  per-slave: R data is addressed to this master
//   RVALID   per-slave RVALID
//   RREADY   per-slave RREADY
//   RLAST    per-slave RLAST
//   RGRANT   one-hot or zero R-channel winner
module axi_arbiter_stom_rr #(
    parameter int NUM_SLV    = 4,
    parameter int RR_MODE    = 1,
    parameter int LOCK_BURST = 1
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_SLV-1:0] BSELECT,
    input  logic [NUM_SLV-1:0] BVALID,
    input  logic [NUM_SLV-1:0] BREADY,
    output logic [NUM_SLV-1:0] BGRANT,
    input  logic [NUM_SLV-1:0] RSELECT,
    input  logic [NUM_SLV-1:0] RVALID,
    input  logic [NUM_SLV-1:0] RREADY,
    input  logic [NUM_SLV-1:0] RLAST,
    output logic [NUM_SLV-1:0] RGRANT
);

    localparam int PW = $clog2(NUM_SLV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Round-robin: first requester at or above ptr, wrapping.
    // Fixed priority: lowest requesting index.
    function automatic logic [NUM_SLV-1:0] pick(input logic [NUM_SLV-1:0] req,
                                                input logic [PW-1:0]      ptr);
        logic [NUM_SLV-1:0] g;
        logic               found;
        logic [PW-1:0]      idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            idx = (RR_MODE != 0) ? PW'((int'(ptr) + k) % NUM_SLV) : PW'(k);
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // Pointer value after the one-hot winner completes: winner+1, wrapping.
    function automatic logic [PW-1:0] next_ptr(input logic [NUM_SLV-1:0] oh);
        logic [PW-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (oh[k]) w = PW'(k);
        end
        return (w == PW'(NUM_SLV - 1)) ? '0 : w + PW'(1);
    endfunction

    // ---------------- B channel ----------------
    state_t             b_state, b_state_nxt;
    logic [PW-1:0]      b_ptr, b_ptr_nxt;
    logic [NUM_SLV-1:0] b_gnt_reg, b_gnt_reg_nxt;
    logic [NUM_SLV-1:0] b_req, b_gnt;
    logic               b_done;

    assign b_req = BSELECT & BVALID;

    always_comb begin
        b_state_nxt   = b_state;
        b_ptr_nxt     = b_ptr;
        b_gnt_reg_nxt = b_gnt_reg;
        b_gnt         = '0;
        if (!ARESET) begin
            b_gnt = (b_state == ST_LOCK) ? b_gnt_reg : pick(b_req, b_ptr);
        end
        // A B response is a single beat, so every handshake completes it.
        b_done = |(b_gnt & BVALID & BREADY);
        case (b_state)
            ST_IDLE: begin
                if (b_gnt != '0) begin
                    if (b_done) begin
                        b_ptr_nxt = next_ptr(b_gnt);
                    end else begin
                        b_gnt_reg_nxt = b_gnt;
                        b_state_nxt   = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (b_done) begin
                    b_state_nxt   = ST_IDLE;
                    b_gnt_reg_nxt = '0;
                    b_ptr_nxt     = next_ptr(b_gnt_reg);
                end
            end
            default: b_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            b_state   <= ST_IDLE;
            b_ptr     <= '0;
            b_gnt_reg <= '0;
        end else begin
            b_state   <= b_state_nxt;
            b_ptr     <= b_ptr_nxt;
            b_gnt_reg <= b_gnt_reg_nxt;
        end
    end

    // ---------------- R channel ----------------
    state_t             r_state, r_state_nxt;
    logic [PW-1:0]      r_ptr, r_ptr_nxt;
    logic [NUM_SLV-1:0] r_gnt_reg, r_gnt_reg_nxt;
    logic [NUM_SLV-1:0] r_req, r_gnt;
    logic               r_hs, r_last_hs, r_done;

    assign r_req = RSELECT & RVALID;

    always_comb begin
        r_state_nxt   = r_state;
        r_ptr_nxt     = r_ptr;
        r_gnt_reg_nxt = r_gnt_reg;
        r_gnt         = '0;
        if (!ARESET) begin
            r_gnt = (r_state == ST_LOCK) ? r_gnt_reg : pick(r_req, r_ptr);
        end
        r_hs      = |(r_gnt & RVALID & RREADY);
        r_last_hs = |(r_gnt & RVALID & RREADY & RLAST);
        // Without burst locking each beat is arbitrated on its own.
        r_done    = (LOCK_BURST != 0) ? r_last_hs : r_hs;
        case (r_state)
            ST_IDLE: begin
                if (r_gnt != '0) begin
                    if (r_done) begin
                        r_ptr_nxt = next_ptr(r_gnt);
                    end else begin
                        r_gnt_reg_nxt = r_gnt;
                        r_state_nxt   = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (r_done) begin
                    r_state_nxt   = ST_IDLE;
                    r_gnt_reg_nxt = '0;
                    r_ptr_nxt     = next_ptr(r_gnt_reg);
                end
            end
            default: r_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gnt_reg <= '0;
        end else begin
            r_state   <= r_state_nxt;
            r_ptr     <= r_ptr_nxt;
            r_gnt_reg <= r_gnt_reg_nxt;
        end
    end

    assign BGRANT = b_gnt;
    assign RGRANT = r_gnt;

endmodule

// File: tb/tb_axi_arbiter_stom_rr.sv
// tb/tb_axi_arbiter_stom_rr.sv - directed bench for axi_arbiter_stom_rr
module tb_axi_arbiter_stom_rr;

    localparam int N = 4;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [N-1:0] BSELECT, BVALID, BREADY;
    logic [N-1:0] RSELECT, RVALID, RREADY, RLAST;
    logic [N-1:0] bgrant_a, rgrant_a, bgrant_b, rgrant_b, bgrant_c, rgrant_c;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    // a: round-robin, burst lock; b: round-robin, no burst lock; c: fixed priority
    axi_arbiter_stom_rr #(.NUM_SLV(N), .RR_MODE(1), .LOCK_BURST(1)) dut_a (
        .ACLK(ACLK), .ARESET(ARESET),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY), .BGRANT(bgrant_a),
        .RSELECT(RSELECT), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RGRANT(rgrant_a)
    );
    axi_arbiter_stom_rr #(.NUM_SLV(N), .RR_MODE(1), .LOCK_BURST(0)) dut_b (
        .ACLK(ACLK), .ARESET(ARESET),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY), .BGRANT(bgrant_b),
        .RSELECT(RSELECT), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RGRANT(rgrant_b)
    );
    axi_arbiter_stom_rr #(.NUM_SLV(N), .RR_MODE(0), .LOCK_BURST(1)) dut_c (
        .ACLK(ACLK), .ARESET(ARESET),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY), .BGRANT(bgrant_c),
        .RSELECT(RSELECT), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RGRANT(rgrant_c)
    );

    // Invariant monitor: one-hot-or-zero grants, and no grant change across a stall.
    logic [N-1:0] mon_g      [6];
    logic [N-1:0] prev_g     [6] = '{default: '0};
    logic         prev_stall [6] = '{default: 1'b0};
    logic         prev_rst = 1'b1;
    logic [N-1:0] mon_v, mon_r;

    always_comb begin
        mon_g[0] = bgrant_a; mon_g[1] = rgrant_a;
        mon_g[2] = bgrant_b; mon_g[3] = rgrant_b;
        mon_g[4] = bgrant_c; mon_g[5] = rgrant_c;
    end

    always @(negedge ACLK) begin
        for (int i = 0; i < 6; i++) begin
            mon_v = (i % 2 == 0) ? BVALID : RVALID;
            mon_r = (i % 2 == 0) ? BREADY : RREADY;
            total++;
            if (!$onehot0(mon_g[i])) begin
                bad++;
                $display("FAIL onehot0 grant%0d actual=%b", i, mon_g[i]);
            end
            if (!ARESET && !prev_rst && prev_stall[i]) begin
                total++;
                if (mon_g[i] !== prev_g[i]) begin
                    bad++;
                    $display("FAIL stall_hold grant%0d actual=%b required=%b", i, mon_g[i], prev_g[i]);
                end
            end
            prev_stall[i] = |(mon_g[i] & mon_v & ~mon_r);
            prev_g[i]     = mon_g[i];
        end
        prev_rst = ARESET;
    end

    localparam logic [3:0] T2_RDY [8] = '{4'b1111, 4'b1101, 4'b1101, 4'b1101,
                                          4'b1111, 4'b1111, 4'b1111, 4'b1111};
    localparam logic [3:0] T2_VLD [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                          4'b0110, 4'b0110, 4'b0110, 4'b0100};
    localparam logic [3:0] T2_LST [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                          4'b0000, 4'b0000, 4'b0010, 4'b0100};
    localparam logic [3:0] T2_EXP [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                          4'b0010, 4'b0010, 4'b0010, 4'b0100};
    localparam logic [3:0] T3_EXP [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0010,
                                          4'b0010, 4'b0100, 4'b0010, 4'b0100};

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        BSELECT = '0; BVALID = '0; BREADY = '0;
        RSELECT = '0; RVALID = '0; RREADY = '0; RLAST = '0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        clear_inputs();
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        ARESET  = 1'b1;
        BSELECT = 4'b1111; BVALID = 4'b1111; BREADY = 4'b1111;
        RSELECT = 4'b1111; RVALID = 4'b1111; RREADY = 4'b1111; RLAST = 4'b1111;
        @(negedge ACLK);
        total++;
        if (bgrant_a !== 4'b0000) begin bad++; $display("FAIL reset_bgrant actual=%b required=0000", bgrant_a); end
        total++;
        if (rgrant_a !== 4'b0000) begin bad++; $display("FAIL reset_rgrant actual=%b required=0000", rgrant_a); end
        total++;
        if (rgrant_c !== 4'b0000) begin bad++; $display("FAIL reset_rgrant_fixed actual=%b required=0000", rgrant_c); end
        tick();
        do_reset();
    endtask

    task automatic test_b_round_robin();
        logic [3:0] exp;
        do_reset();
        BSELECT = 4'b1111; BVALID = 4'b1111; BREADY = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp = 4'b0001 << (k % 4);
            @(negedge ACLK);
            total++;
            if (bgrant_a !== exp) begin
                bad++;
                $display("FAIL b_rr cycle%0d actual=%b required=%b", k, bgrant_a, exp);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_r_burst_lock();
        do_reset();
        RSELECT = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            RVALID = T2_VLD[k]; RREADY = T2_RDY[k]; RLAST = T2_LST[k];
            @(negedge ACLK);
            total++;
            if (rgrant_a !== T2_EXP[k]) begin
                bad++;
                $display("FAIL r_burst_lock cycle%0d actual=%b required=%b", k, rgrant_a, T2_EXP[k]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_r_no_lock();
        do_reset();
        RSELECT = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            RVALID = T2_VLD[k]; RREADY = T2_RDY[k]; RLAST = T2_LST[k];
            @(negedge ACLK);
            total++;
            if (rgrant_b !== T3_EXP[k]) begin
                bad++;
                $display("FAIL r_no_lock cycle%0d actual=%b required=%b", k, rgrant_b, T3_EXP[k]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_b_stall_hold();
        do_reset();
        BSELECT = 4'b1001; BVALID = 4'b1001; BREADY = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            total++;
            if (bgrant_a !== 4'b0001) begin
                bad++;
                $display("FAIL b_stall cycle%0d actual=%b required=0001", k, bgrant_a);
            end
            tick();
        end
        BREADY = 4'b1111;
        @(negedge ACLK);
        total++;
        if (bgrant_a !== 4'b0001) begin bad++; $display("FAIL b_stall_release actual=%b required=0001", bgrant_a); end
        tick();
        // slave 0 keeps requesting but just completed, so slave 3 goes first
        @(negedge ACLK);
        total++;
        if (bgrant_a !== 4'b1000) begin bad++; $display("FAIL b_after_stall actual=%b required=1000", bgrant_a); end
        tick();
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        logic [3:0] exp_rr;
        do_reset();
        RSELECT = 4'b0101; RVALID = 4'b0101; RREADY = 4'b1111; RLAST = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_rr = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            @(negedge ACLK);
            total++;
            if (rgrant_c !== 4'b0001) begin
                bad++;
                $display("FAIL fixed_prio cycle%0d actual=%b required=0001", k, rgrant_c);
            end
            total++;
            if (rgrant_a !== exp_rr) begin
                bad++;
                $display("FAIL rr_contrast cycle%0d actual=%b required=%b", k, rgrant_a, exp_rr);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        RSELECT = 4'b1000; RVALID = 4'b1000; RREADY = 4'b1111; RLAST = 4'b0000;
        @(negedge ACLK);
        total++;
        if (rgrant_a !== 4'b1000) begin bad++; $display("FAIL mid_burst_beat1 actual=%b required=1000", rgrant_a); end
        tick();
        ARESET = 1'b1;
        @(negedge ACLK);
        total++;
        if (rgrant_a !== 4'b0000) begin bad++; $display("FAIL mid_burst_reset actual=%b required=0000", rgrant_a); end
        tick();
        ARESET  = 1'b0;
        RSELECT = 4'b1010; RVALID = 4'b1010;
        @(negedge ACLK);
        total++;
        if (rgrant_a !== 4'b0010) begin bad++; $display("FAIL after_reset actual=%b required=0010", rgrant_a); end
        tick();
        clear_inputs();
    endtask

    initial begin
        ARESET = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_b_round_robin();
        test_r_burst_lock();
        test_r_no_lock();
        test_b_stall_hold();
        test_fixed_priority();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
